// File: rtl/imm_ext_pkg.sv
// Shared definitions for the immediate-extend stage: format codes, field
// positions, buffer occupancy encodings and the buffer entry record.
package imm_ext_pkg;

  localparam logic [2:0] IMM_I  = 3'b000;
  localparam logic [2:0] IMM_D  = 3'b001;
  localparam logic [2:0] IMM_B  = 3'b010;
  localparam logic [2:0] IMM_CB = 3'b011;
  localparam logic [2:0] IMM_IW = 3'b100;

  localparam int unsigned I_MSB  = 21;
  localparam int unsigned I_LSB  = 10;
  localparam int unsigned D_MSB  = 20;
  localparam int unsigned D_LSB  = 12;
  localparam int unsigned B_MSB  = 25;
  localparam int unsigned B_LSB  = 0;
  localparam int unsigned CB_MSB = 23;
  localparam int unsigned CB_LSB = 5;
  localparam int unsigned IW_MSB = 20;
  localparam int unsigned IW_LSB = 5;
  localparam int unsigned HW_MSB = 22;
  localparam int unsigned HW_LSB = 21;

  // Buffer occupancy; the state is the entry count itself.
  localparam logic [1:0] BUF_EMPTY = 2'd0;
  localparam logic [1:0] BUF_ONE   = 2'd1;
  localparam logic [1:0] BUF_TWO   = 2'd2;

  // Entries are sized for the widest legal configuration (DATA_W <= 64, TAG_W <= 32).
  localparam int unsigned ENTRY_IMM_W = 64;
  localparam int unsigned ENTRY_TAG_W = 32;

  typedef struct packed {
    logic [ENTRY_IMM_W-1:0] imm;
    logic [ENTRY_TAG_W-1:0] tag;
    logic                   illegal;
  } entry_t;

endpackage

// File: rtl/imm_ext_decode.sv
// Combinational immediate extension for the I, D, B, CB and IW formats;
// illegal codes and out-of-range IW shifts yield zero with illegal set.
module imm_ext_decode
  import imm_ext_pkg::*;
#(
  parameter int unsigned DATA_W = 64
) (
  input  logic [25:0]       imm,
  input  logic [2:0]        ctrl,
  output logic [DATA_W-1:0] imm_out,
  output logic              illegal
);

  logic [63:0] ext;
  logic [1:0]  hw;
  logic [15:0] wide;

  assign hw   = imm[HW_MSB:HW_LSB];
  assign wide = imm[IW_MSB:IW_LSB];

  always_comb begin
    ext     = '0;
    illegal = 1'b0;
    case (ctrl)
      IMM_I:  ext = {{52{imm[I_MSB]}}, imm[I_MSB:I_LSB]};
      IMM_D:  ext = {{55{imm[D_MSB]}}, imm[D_MSB:D_LSB]};
      IMM_B:  ext = {{36{imm[B_MSB]}}, imm[B_MSB:B_LSB], 2'b00};
      IMM_CB: ext = {{43{imm[CB_MSB]}}, imm[CB_MSB:CB_LSB], 2'b00};
      IMM_IW: begin
        // A 32-bit datapath cannot represent hw = 2 or 3.
        if ((DATA_W < 64) && hw[1]) begin
          illegal = 1'b1;
        end else begin
          case (hw)
            2'd0:    ext = {48'h0, wide};
            2'd1:    ext = {32'h0, wide, 16'h0};
            2'd2:    ext = {16'h0, wide, 32'h0};
            default: ext = {wide, 48'h0};
          endcase
        end
      end
      default: illegal = 1'b1;
    endcase
  end

  assign imm_out = ext[DATA_W-1:0];

endmodule

// File: rtl/imm_extend_stage.sv
// Pipelined immediate generator with a 2-entry elastic output buffer.
// Optional sticky error trap enabled by defining IMM_EXT_ERR_TRAP_EN.
module imm_extend_stage
  import imm_ext_pkg::*;
#(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned TAG_W  = 8
) (
  input  logic              CLK,
  input  logic              Reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [25:0]       in_imm,
  input  logic [2:0]        in_ctrl,
  input  logic [TAG_W-1:0]  in_tag,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_imm,
  output logic [TAG_W-1:0]  out_tag,
  output logic              out_illegal,
  output logic              err_sticky
);

  logic [DATA_W-1:0] dec_imm;
  logic              dec_illegal;
  entry_t            mem [2];
  entry_t            new_entry;
  entry_t            head;
  logic [1:0]        count;
  logic [1:0]        count_nxt;
  logic              wr_ptr;
  logic              rd_ptr;
  logic              in_ready_q;
  logic              accept;
  logic              pop;
  logic              unused_entry_bits;

  imm_ext_decode #(.DATA_W(DATA_W)) u_decode (
    .imm     (in_imm),
    .ctrl    (in_ctrl),
    .imm_out (dec_imm),
    .illegal (dec_illegal)
  );

  assign accept = in_valid & in_ready_q;
  assign pop    = out_valid & out_ready;

  always_comb begin
    new_entry         = '0;
    new_entry.imm     = ENTRY_IMM_W'(dec_imm);
    new_entry.tag     = ENTRY_TAG_W'(in_tag);
    new_entry.illegal = dec_illegal;
  end

  always_comb begin
    count_nxt = count;
    case (count)
      BUF_EMPTY: if (accept) count_nxt = BUF_ONE;
      BUF_ONE: begin
        if (accept && !pop)      count_nxt = BUF_TWO;
        else if (pop && !accept) count_nxt = BUF_EMPTY;
      end
      BUF_TWO:   if (pop) count_nxt = BUF_ONE;
      default:   count_nxt = BUF_EMPTY;
    endcase
  end

  // in_ready is registered from the next count so it never sees out_ready combinationally.
  always_ff @(posedge CLK) begin
    if (Reset) begin
      count      <= BUF_EMPTY;
      wr_ptr     <= 1'b0;
      rd_ptr     <= 1'b0;
      in_ready_q <= 1'b1;
      mem[0]     <= '0;
      mem[1]     <= '0;
    end else begin
      count      <= count_nxt;
      in_ready_q <= (count_nxt != BUF_TWO);
      if (accept) begin
        mem[wr_ptr] <= new_entry;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
    end
  end

  assign head        = mem[rd_ptr];
  assign in_ready    = in_ready_q;
  assign out_valid   = (count != BUF_EMPTY);
  assign out_imm     = head.imm[DATA_W-1:0];
  assign out_tag     = head.tag[TAG_W-1:0];
  assign out_illegal = head.illegal;

  assign unused_entry_bits = ^{head.imm, head.tag};

`ifdef IMM_EXT_ERR_TRAP_EN
  logic err_q;

  always_ff @(posedge CLK) begin
    if (Reset) begin
      err_q <= 1'b0;
    end else if (accept && dec_illegal) begin
      err_q <= 1'b1;
    end
  end

  assign err_sticky = err_q;
`else
  assign err_sticky = 1'b0;
`endif

endmodule
